cache_mem_block_responder: RTL and testbench

// Memory-side responder for the cache-to-memory-controller command/buffer interface. Accepts word or

---
 rtl/cache_mem_block_responder_if.sv | 51 +++++
 rtl/cache_mem_block_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_cache_mem_block_responder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_block_responder_if.sv
// Cache <-> memory-responder bundle.
// Purpose: groups the cache command/buffer handshake and the backing-memory port so that the
// responder and its environment (cache controller plus memory model) connect through one bundle.
// Modports:
//   slave  - the responder: takes cache requests/data and memory responses, drives ready flags,
//            read data, the memory command port and the error flag.
//   master - the environment: drives cache requests/data and memory ready/valid/data.
interface cache_mem_block_responder_if #(
    parameter int unsigned BW_ADDR = 26
);
    // cache side
    logic               cache_req_i;
    logic               cache_req_block_i;
    logic               cache_rw_i;
    logic [BW_ADDR-1:0] cache_add_i;
    logic               cache_write_i;
    logic               cache_read_i;
    logic [31:0]        cache_data_i;
    logic               cache_ready_req_o;
    logic               cache_ready_write_o;
    logic               cache_ready_read_o;
    logic [31:0]        cache_data_o;
    // memory side
    logic               mem_req_o;
    logic               mem_rw_o;
    logic [BW_ADDR-1:0] mem_add_o;
    logic [31:0]        mem_data_o;
    logic               mem_ready_i;
    logic               mem_valid_i;
    logic [31:0]        mem_data_i;
    // status
    logic               err_o;

    modport slave (
        input  cache_req_i, cache_req_block_i, cache_rw_i, cache_add_i,
        input  cache_write_i, cache_read_i, cache_data_i,
        output cache_ready_req_o, cache_ready_write_o, cache_ready_read_o, cache_data_o,
        output mem_req_o, mem_rw_o, mem_add_o, mem_data_o,
        input  mem_ready_i, mem_valid_i, mem_data_i,
        output err_o
    );

    modport master (
        output cache_req_i, cache_req_block_i, cache_rw_i, cache_add_i,
        output cache_write_i, cache_read_i, cache_data_i,
        input  cache_ready_req_o, cache_ready_write_o, cache_ready_read_o, cache_data_o,
        input  mem_req_o, mem_rw_o, mem_add_o, mem_data_o,
        output mem_ready_i, mem_valid_i, mem_data_i,
        input  err_o
    );
endinterface

// File: rtl/cache_mem_block_responder.sv
// Memory-side responder for the cache command/buffer interface.
// Purpose: accepts word or block requests from a cache controller. Reads are fetched from backing
// memory into a show-ahead FIFO that the cache pops; writes are buffered from the cache into the
// same FIFO and then drained to backing memory in address order.
// Ports:
//   clock_i - single clock, all logic on the rising edge
//   reset_i - synchronous active-high reset; every output is forced low while it is asserted
//   bus     - slave modport of cache_mem_block_responder_if (cache handshake, memory port, err_o)
module cache_mem_block_responder #(
    parameter int unsigned BW_ADDR  = 26,
    parameter int unsigned BW_BLOCK = 4
) (
    input logic                         clock_i,
    input logic                         reset_i,
    cache_mem_block_responder_if.slave  bus
);

    localparam int unsigned Depth = 2 ** BW_BLOCK;
    localparam int unsigned CW    = BW_BLOCK + 1;

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdDrain,
        StWrFill,
        StWrIssue
    } state_e;

    state_e             state_q, state_d;
    logic [BW_ADDR-1:0] base_q, base_d;
    logic               block_q, block_d;
    logic [CW-1:0]      issue_cnt_q, issue_cnt_d;  // memory accesses accepted
    logic [CW-1:0]      resp_cnt_q, resp_cnt_d;    // read responses taken
    logic [CW-1:0]      xfer_cnt_q, xfer_cnt_d;    // cache pops (read) or pushes (write)
    logic               err_q, err_d;

    // FIFO shared by the read and write paths; only one direction is active at a time.
    logic [31:0]         fifo_q [Depth];
    logic [BW_BLOCK-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                fifo_empty;
    logic                push, pop, clear_fifo;
    logic [31:0]         push_data;

    logic [CW-1:0]      n_words;
    logic               is_rd;
    logic               ready_req, ready_write, ready_read;
    logic               mem_req, mem_rw;
    logic [BW_ADDR-1:0] mem_add;
    logic [31:0]        mem_wdata;

    assign n_words    = block_q ? CW'(Depth) : CW'(1);
    assign fifo_empty = (count_q == '0);
    assign is_rd      = (state_q == StRdIssue) || (state_q == StRdDrain);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        block_d     = block_q;
        issue_cnt_d = issue_cnt_q;
        resp_cnt_d  = resp_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        err_d       = err_q;
        push        = 1'b0;
        pop         = 1'b0;
        clear_fifo  = 1'b0;
        push_data   = bus.mem_data_i;
        ready_req   = 1'b0;
        mem_req     = 1'b0;
        mem_rw      = 1'b0;
        mem_add     = '0;
        mem_wdata   = '0;

        ready_read  = is_rd && !fifo_empty;
        ready_write = (state_q == StWrFill) && (xfer_cnt_q < n_words);

        // Protocol violations are flagged and otherwise ignored.
        if (bus.cache_read_i) begin
            if (ready_read) begin
                pop = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (bus.cache_write_i) begin
            if (ready_write) begin
                push      = 1'b1;
                push_data = bus.cache_data_i;
            end else begin
                err_d = 1'b1;
            end
        end

        // Responses beyond the N-th, or outside a read, are dropped.
        if (bus.mem_valid_i) begin
            if (is_rd && (resp_cnt_q < n_words)) begin
                push       = 1'b1;
                push_data  = bus.mem_data_i;
                resp_cnt_d = resp_cnt_q + CW'(1);
            end else begin
                err_d = 1'b1;
            end
        end

        if (bus.cache_req_i && (state_q != StIdle)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                ready_req = 1'b1;
                if (bus.cache_req_i) begin
                    base_d      = bus.cache_req_block_i ?
                                  (bus.cache_add_i & ~BW_ADDR'(Depth - 1)) : bus.cache_add_i;
                    block_d     = bus.cache_req_block_i;
                    issue_cnt_d = '0;
                    resp_cnt_d  = '0;
                    xfer_cnt_d  = '0;
                    clear_fifo  = 1'b1;
                    state_d     = bus.cache_rw_i ? StWrFill : StRdIssue;
                end
            end
            StRdIssue: begin
                mem_req = 1'b1;
                mem_add = base_q + BW_ADDR'(issue_cnt_q);
                if (bus.mem_ready_i) begin
                    issue_cnt_d = issue_cnt_q + CW'(1);
                    if (issue_cnt_q == n_words - CW'(1)) begin
                        state_d = StRdDrain;
                    end
                end
            end
            StRdDrain: begin
            end
            StWrFill: begin
                if (push) begin
                    xfer_cnt_d = xfer_cnt_q + CW'(1);
                    if (xfer_cnt_q == n_words - CW'(1)) begin
                        state_d = StWrIssue;
                    end
                end
            end
            StWrIssue: begin
                mem_req   = 1'b1;
                mem_rw    = 1'b1;
                mem_add   = base_q + BW_ADDR'(issue_cnt_q);
                mem_wdata = fifo_q[rd_ptr_q];
                if (bus.mem_ready_i) begin
                    pop         = 1'b1;
                    issue_cnt_d = issue_cnt_q + CW'(1);
                    if (issue_cnt_q == n_words - CW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The N-th cache pop closes a read regardless of issue progress.
        if (is_rd && pop) begin
            xfer_cnt_d = xfer_cnt_q + CW'(1);
            if (xfer_cnt_q == n_words - CW'(1)) begin
                state_d = StIdle;
            end
        end
    end

    // Outputs are held low for the whole reset cycle.
    always_comb begin
        bus.cache_ready_req_o   = 1'b0;
        bus.cache_ready_write_o = 1'b0;
        bus.cache_ready_read_o  = 1'b0;
        bus.cache_data_o        = '0;
        bus.mem_req_o           = 1'b0;
        bus.mem_rw_o            = 1'b0;
        bus.mem_add_o           = '0;
        bus.mem_data_o          = '0;
        bus.err_o               = 1'b0;
        if (!reset_i) begin
            bus.cache_ready_req_o   = ready_req;
            bus.cache_ready_write_o = ready_write;
            bus.cache_ready_read_o  = ready_read;
            bus.cache_data_o        = fifo_q[rd_ptr_q];
            bus.mem_req_o           = mem_req;
            bus.mem_rw_o            = mem_rw;
            bus.mem_add_o           = mem_add;
            bus.mem_data_o          = mem_wdata;
            bus.err_o               = err_q;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            base_q      <= '0;
            block_q     <= 1'b0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            xfer_cnt_q  <= '0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            block_q     <= block_d;
            issue_cnt_q <= issue_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
            err_q       <= err_d;
            if (clear_fifo) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + BW_BLOCK'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + BW_BLOCK'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock_i) begin
        if (push && !reset_i) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_cache_mem_block_responder.sv
module tb_cache_mem_block_responder;

    localparam int unsigned BW_ADDR  = 26;
    localparam int unsigned BW_BLOCK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_block_responder_if #(.BW_ADDR(BW_ADDR)) bus ();

    cache_mem_block_responder #(
        .BW_ADDR (BW_ADDR),
        .BW_BLOCK(BW_BLOCK)
    ) dut (
        .clock_i(clk),
        .reset_i(rst),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- memory model: latency 2, logs accepted accesses ----------------
    int                 cyc = 0;
    bit                 rdy_toggle = 1'b0;
    logic               pend_v = 1'b0;
    logic               pend_rw = 1'b0;
    logic [25:0]        pend_add = '0;
    logic [31:0]        pend_data = '0;
    logic [25:0]        rd_log[$];
    logic [25:0]        wr_add_log[$];
    logic [31:0]        wr_dat_log[$];
    logic [31:0]        resp_q[$];
    int                 due_q[$];

    function automatic logic [31:0] mem_word(input logic [25:0] a);
        return 32'hA500_0000 ^ {6'd0, a};
    endfunction

    initial begin : mem_model
        int d;
        bus.mem_ready_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            // Commit the access decided last negedge unless reset swallowed that edge.
            if (pend_v && !rst) begin
                if (pend_rw) begin
                    wr_add_log.push_back(pend_add);
                    wr_dat_log.push_back(pend_data);
                end else begin
                    rd_log.push_back(pend_add);
                    resp_q.push_back(mem_word(pend_add));
                    due_q.push_back(cyc + 1);
                end
            end
            if (rst) begin
                resp_q.delete();
                due_q.delete();
            end
            if (resp_q.size() > 0 && due_q[0] <= cyc) begin
                bus.mem_valid_i = 1'b1;
                bus.mem_data_i  = resp_q.pop_front();
                d = due_q.pop_front();
            end else begin
                bus.mem_valid_i = 1'b0;
                bus.mem_data_i  = '0;
            end
            bus.mem_ready_i = rdy_toggle ? ~bus.mem_ready_i : 1'b1;
            pend_v    = bus.mem_req_o && bus.mem_ready_i;
            pend_rw   = bus.mem_rw_o;
            pend_add  = bus.mem_add_o;
            pend_data = bus.mem_data_o;
        end
    end

    // ---------------- cache-side stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_read(input logic [25:0] addr, input bit block, input int pop_every,
                            input bit inject, input string tag);
        int n, popped, c, bad;
        bit req_done;
        logic [25:0] base;
        n    = block ? 16 : 1;
        base = block ? {addr[25:4], 4'h0} : addr;
        rd_log.delete();
        bus.cache_req_i       = 1'b1;
        bus.cache_req_block_i = block;
        bus.cache_rw_i        = 1'b0;
        bus.cache_add_i       = addr;
        tick();
        bus.cache_req_i = 1'b0;
        popped   = 0;
        c        = 0;
        req_done = 1'b0;
        while (popped < n && c < 400) begin
            bus.cache_read_i = 1'b0;
            bus.cache_req_i  = 1'b0;
            if (inject && c == 0) begin
                bus.cache_read_i = 1'b1;  // FIFO still empty here
            end else if (inject && !req_done && !bus.mem_req_o) begin
                bus.cache_req_i = 1'b1;   // issue finished, transfer draining
                req_done = 1'b1;
            end else if ((c % pop_every) == 0 && bus.cache_ready_read_o) begin
                check({tag, "_data"}, bus.cache_data_o, mem_word(base + 26'(popped)));
                bus.cache_read_i = 1'b1;
                popped++;
            end
            tick();
            c++;
        end
        bus.cache_read_i = 1'b0;
        bus.cache_req_i  = 1'b0;
        check({tag, "_popped"}, popped, n);
        check({tag, "_ready_req"}, {31'd0, bus.cache_ready_req_o}, 32'd1);
        check({tag, "_nreads"}, rd_log.size(), n);
        bad = 0;
        for (int k = 0; k < rd_log.size() && k < n; k++) begin
            if (rd_log[k] != base + 26'(k)) bad++;
        end
        check({tag, "_addr_order"}, bad, 0);
    endtask

    task automatic run_write(input logic [25:0] addr, input bit block, input logic [31:0] dbase,
                             input bit toggle, input int abort_after, input string tag);
        int n, fill, c, bad;
        logic [25:0] base;
        n    = block ? 16 : 1;
        base = block ? {addr[25:4], 4'h0} : addr;
        wr_add_log.delete();
        wr_dat_log.delete();
        rdy_toggle            = toggle;
        bus.cache_req_i       = 1'b1;
        bus.cache_req_block_i = block;
        bus.cache_rw_i        = 1'b1;
        bus.cache_add_i       = addr;
        tick();
        bus.cache_req_i = 1'b0;
        bus.cache_rw_i  = 1'b0;
        fill = 0;
        c    = 0;
        while (fill < n && c < 100) begin
            bus.cache_write_i = 1'b0;
            if (bus.cache_ready_write_o) begin
                bus.cache_write_i = 1'b1;
                bus.cache_data_i  = dbase + fill;
                fill++;
            end
            tick();
            c++;
        end
        bus.cache_write_i = 1'b0;
        check({tag, "_filled"}, fill, n);
        check({tag, "_ready_write_off"}, {31'd0, bus.cache_ready_write_o}, 32'd0);
        if (abort_after > 0) begin
            c = 0;
            while (wr_add_log.size() < abort_after && c < 200) begin
                tick();
                c++;
            end
            check({tag, "_pre_abort"}, wr_add_log.size(), abort_after);
            rst = 1'b1;
            tick();
            check({tag, "_mem_req_in_rst"}, {31'd0, bus.mem_req_o}, 32'd0);
            check({tag, "_ready_req_in_rst"}, {31'd0, bus.cache_ready_req_o}, 32'd0);
            rst = 1'b0;
            tick();
            check({tag, "_mem_req_after"}, {31'd0, bus.mem_req_o}, 32'd0);
            check({tag, "_ready_req_after"}, {31'd0, bus.cache_ready_req_o}, 32'd1);
            check({tag, "_err_after"}, {31'd0, bus.err_o}, 32'd0);
            tick();
            check({tag, "_nwrites"}, wr_add_log.size(), abort_after);
        end else begin
            c = 0;
            while (!bus.cache_ready_req_o && c < 200) begin
                tick();
                c++;
            end
            check({tag, "_ready_req"}, {31'd0, bus.cache_ready_req_o}, 32'd1);
            check({tag, "_nwrites"}, wr_add_log.size(), n);
            bad = 0;
            for (int k = 0; k < wr_add_log.size() && k < n; k++) begin
                if (wr_add_log[k] != base + 26'(k) || wr_dat_log[k] != dbase + k) bad++;
            end
            check({tag, "_order"}, bad, 0);
        end
        rdy_toggle = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        bus.cache_req_i       = 1'b0;
        bus.cache_req_block_i = 1'b0;
        bus.cache_rw_i        = 1'b0;
        bus.cache_add_i       = '0;
        bus.cache_write_i     = 1'b0;
        bus.cache_read_i      = 1'b0;
        bus.cache_data_i      = '0;

        // reset behaviour
        rst = 1'b1;
        tick();
        tick();
        check("rst_ready_req", {31'd0, bus.cache_ready_req_o}, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready_req", {31'd0, bus.cache_ready_req_o}, 32'd1);
        check("post_rst_err", {31'd0, bus.err_o}, 32'd0);
        check("post_rst_ready_read", {31'd0, bus.cache_ready_read_o}, 32'd0);
        check("post_rst_ready_write", {31'd0, bus.cache_ready_write_o}, 32'd0);

        // block read at 0x123, cache pops as soon as data is there
        run_read(26'h123, 1'b1, 1, 1'b0, "rd_blk");
        check("rd_blk_err", {31'd0, bus.err_o}, 32'd0);

        // single-word write
        run_write(26'h55, 1'b0, 32'hDEADBEEF, 1'b0, 0, "wr_word");
        check("wr_word_add", {6'd0, wr_add_log.size() > 0 ? wr_add_log[0] : 26'h0}, 32'h55);
        check("wr_word_data", wr_dat_log.size() > 0 ? wr_dat_log[0] : 32'h0, 32'hDEADBEEF);

        // block write with memory ready every other cycle
        run_write(26'h34B, 1'b1, 32'h1000_0000, 1'b1, 0, "wr_tog");
        check("wr_tog_err", {31'd0, bus.err_o}, 32'd0);

        // slow consumer: pops only every third cycle
        run_read(26'h7A5, 1'b1, 3, 1'b0, "rd_slow");
        check("rd_slow_err", {31'd0, bus.err_o}, 32'd0);

        // single-word read
        run_read(26'h3_0001, 1'b0, 1, 1'b0, "rd_word");

        // protocol errors during a read; transfer must complete intact
        run_read(26'h200, 1'b1, 4, 1'b1, "rd_err");
        check("rd_err_flag", {31'd0, bus.err_o}, 32'd1);
        tick();
        tick();
        check("rd_err_sticky", {31'd0, bus.err_o}, 32'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("err_cleared", {31'd0, bus.err_o}, 32'd0);

        // reset in the middle of draining a block write
        run_write(26'h800, 1'b1, 32'h2000_0000, 1'b0, 5, "wr_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
